// File: rtl/hpdcache_sram_wmask_ctrl.sv
// hpdcache_sram_wmask_ctrl: valid/ready front end for a 1RW masked-write SRAM.
// Reads return through a credit-protected response FIFO, so read data is never dropped.
// Optional zero sweep of the array after reset: define HPDCACHE_SRAM_CTRL_INIT_EN.
module hpdcache_sram_wmask_ctrl #(
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned DEPTH     = 2**ADDR_SIZE,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  input  logic [DATA_SIZE-1:0] req_wmask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [ADDR_SIZE-1:0] sram_addr,
  output logic [DATA_SIZE-1:0] sram_wdata,
  output logic [DATA_SIZE-1:0] sram_wmask,
  input  logic [DATA_SIZE-1:0] sram_rdata
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  logic                 idle;
  logic                 req_fire;
  logic                 push;
  logic                 pop;
  logic                 has_credit;
  logic [CNT_W:0]       used;
  logic                 rd_inflight;
  logic [CNT_W-1:0]     occ;
  logic [PTR_W-1:0]     wptr;
  logic [PTR_W-1:0]     rptr;
  logic [DATA_SIZE-1:0] fifo_mem [RSP_DEPTH];

`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
  typedef enum logic {INIT, IDLE} state_t;

  state_t               state;
  state_t               state_next;
  logic [ADDR_SIZE-1:0] init_cnt;
  logic [ADDR_SIZE-1:0] init_cnt_next;

  // State register and sweep address counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
    end
  end

  // Sweep sequencing: leave INIT once the last valid word has been written
  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    if (state == INIT) begin
      init_cnt_next = init_cnt + ADDR_SIZE'(1);
      if (init_cnt == ADDR_SIZE'(DEPTH - 1)) begin
        state_next = IDLE;
      end
    end
  end

  assign idle = (state == IDLE);
  assign busy = (state == INIT);
`else
  assign idle = 1'b1;
  assign busy = 1'b0;
`endif

  // Reads need a free response slot; a pop in the same cycle releases one
  always_comb begin
    used       = (CNT_W+1)'(occ) + (CNT_W+1)'(rd_inflight) - (CNT_W+1)'(pop);
    has_credit = (used < (CNT_W+1)'(RSP_DEPTH));
    req_ready  = idle && (req_we || has_credit);
    req_fire   = req_valid && req_ready;
  end

  // SRAM port: request pass-through, overridden by the zero sweep while busy
  always_comb begin
    sram_cs    = req_fire;
    sram_we    = req_fire && req_we;
    sram_addr  = req_addr;
    sram_wdata = req_wdata;
    sram_wmask = req_wmask;
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    if (state == INIT) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = init_cnt;
      sram_wdata = '0;
      sram_wmask = '1;
    end
`endif
  end

  assign push      = rd_inflight;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = (occ != '0);
  assign rsp_rdata = fifo_mem[rptr];

  // Read-in-flight flag: SRAM data is valid the cycle after the read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= req_fire && !req_we;
    end
  end

  // Response FIFO: circular buffer with wrapping pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wptr] <= sram_rdata;
        wptr <= (wptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= (rptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Credits must make a push into a full FIFO impossible
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (occ == CNT_W'(RSP_DEPTH))));

  // Every SRAM access must target a populated word
  a_addr_in_range: assert property (@(posedge clk) disable iff (rst)
    sram_cs |-> (32'(sram_addr) < DEPTH));

endmodule

// File: tb/tb_hpdcache_sram_wmask_ctrl.sv
// Directed bench for hpdcache_sram_wmask_ctrl with an SRAM model, a reference memory
// and an in-order scoreboard of expected read data.
// Sweep checks are enabled when HPDCACHE_SRAM_CTRL_INIT_EN is defined.
`timescale 1ns/1ps
module tb_hpdcache_sram_wmask_ctrl;

  localparam int unsigned ADDR_SIZE = 6;
  localparam int unsigned DATA_SIZE = 64;
  localparam int unsigned DEPTH     = 64;
  localparam int unsigned RSP_DEPTH = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [DATA_SIZE-1:0] req_wdata;
  logic [DATA_SIZE-1:0] req_wmask;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_SIZE-1:0] rsp_rdata;
  logic                 busy;
  logic                 sram_cs;
  logic                 sram_we;
  logic [ADDR_SIZE-1:0] sram_addr;
  logic [DATA_SIZE-1:0] sram_wdata;
  logic [DATA_SIZE-1:0] sram_wmask;
  logic [DATA_SIZE-1:0] sram_rdata = '0;

  logic [DATA_SIZE-1:0] sram_mem [DEPTH] = '{default: '0};
  logic [DATA_SIZE-1:0] ref_mem  [DEPTH] = '{default: '0};
  logic [DATA_SIZE-1:0] exp_q [$];

  int tests = 0;
  int fails = 0;

  hpdcache_sram_wmask_ctrl #(
    .ADDR_SIZE(ADDR_SIZE),
    .DATA_SIZE(DATA_SIZE),
    .DEPTH    (DEPTH),
    .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_wmask(sram_wmask),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // 1RW masked-write SRAM model, read data valid the cycle after the read
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare pops, then record the request that will fire at the next edge
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        check("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          check("rsp_data", rsp_rdata, exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        check("accept_cs", 64'(sram_cs), 64'd1);
        if (req_we) begin
          ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [ADDR_SIZE-1:0] addr,
                        input logic [DATA_SIZE-1:0] data, input logic [DATA_SIZE-1:0] mask);
    logic ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    req_wmask = mask;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) check("req_timeout", 64'(ok), 64'd1);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    rsp_ready = 1'b0;
    @(negedge clk);
    check("drain_no_valid", 64'(rsp_valid), 64'd0);
    cyc();
  endtask

  function automatic logic [DATA_SIZE-1:0] pat(input int i);
    return {32'(i) ^ 32'h5A5A_0000, 32'hC0DE_0000 + 32'(i)};
  endfunction

  initial begin
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    rsp_ready = 1'b0;
    rst       = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_req_ready", 64'(req_ready), 64'd0);
`else
    check("rst_busy", 64'(busy), 64'd0);
`endif
    cyc();
    rst = 1'b0;

`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    // Zero sweep with a read request held pending throughout
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(negedge clk);
      check("sweep_busy_noready", {62'd0, busy, req_ready}, 64'd2);
      check("sweep_cs_we", {62'd0, sram_cs, sram_we}, 64'd3);
      check("sweep_addr", 64'(sram_addr), 64'(i));
      check("sweep_data_mask", 64'((sram_wdata == '0) && (sram_wmask == '1)), 64'd1);
      cyc();
    end
    req_valid = 1'b0;
`endif
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_ready", 64'(req_ready), 64'd1);
    cyc();

    // Masked write then read, 1-cycle read-to-valid latency
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 6'd5;
    req_wdata = '1;
    req_wmask = 64'h0000_0000_FFFF_0000;
    @(negedge clk);
    check("wr_cs_we", {62'd0, sram_cs, sram_we}, 64'd3);
    check("wr_mask", sram_wmask, 64'h0000_0000_FFFF_0000);
    cyc();
    req_we = 1'b0;
    @(negedge clk);
    check("rd_cs_we", {62'd0, sram_cs, sram_we}, 64'd2);
    check("rd_addr", 64'(sram_addr), 64'd5);
    cyc();
    req_valid = 1'b0;
    @(negedge clk);
    check("rd_lat_early", 64'(rsp_valid), 64'd0);
    cyc();
    @(negedge clk);
    check("rd_lat_valid", 64'(rsp_valid), 64'd1);
    check("rd_masked_data", rsp_rdata, 64'h0000_0000_FFFF_0000);
    cyc();
    drain();

    // Credit backpressure with RSP_DEPTH=2
    for (int i = 1; i <= 3; i++) do_req(1'b1, 6'(i), pat(i), '1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 6'd1;
    @(negedge clk);
    check("bp_rd1_ready", 64'(req_ready), 64'd1);
    cyc();
    req_addr = 6'd2;
    @(negedge clk);
    check("bp_rd2_ready", 64'(req_ready), 64'd1);
    cyc();
    req_addr = 6'd3;
    @(negedge clk);
    check("bp_rd3_stall", 64'(req_ready), 64'd0);
    cyc();
    @(negedge clk);
    check("bp_rd3_stall_full", 64'(req_ready), 64'd0);
    check("bp_full_valid", 64'(rsp_valid), 64'd1);
    cyc();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_frees", 64'(req_ready), 64'd1);
    check("bp_head", rsp_rdata, pat(1));
    cyc();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    drain();

    // Streaming reads with concurrent push and pop across pointer wrap
    for (int i = 8; i < 16; i++) do_req(1'b1, 6'(i), pat(i), '1);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = 6'(8 + i);
      @(negedge clk);
      check("stream_ready", 64'(req_ready), 64'd1);
      if (i >= 2) check("stream_valid", 64'(rsp_valid), 64'd1);
      cyc();
    end
    req_valid = 1'b0;
    drain();

    // Writes accepted while the FIFO is full, FIFO contents unchanged
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 6'd8;
    cyc();
    req_addr  = 6'd9;
    cyc();
    req_valid = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 6'(8 + (i % 2));
      req_wdata = '0;
      req_wmask = '1;
      @(negedge clk);
      check("full_wr_ready", 64'(req_ready), 64'd1);
      check("full_wr_cs_we", {62'd0, sram_cs, sram_we}, 64'd3);
      check("full_head", rsp_rdata, pat(8));
      cyc();
    end
    req_valid = 1'b0;
    drain();

    // Reset the cycle after a read issues
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 6'd10;
    @(negedge clk);
    check("rst_rd_ready", 64'(req_ready), 64'd1);
    cyc();
    req_valid = 1'b0;
    rst       = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    check("midrst_busy", 64'(busy), 64'd1);
    check("midrst_addr", 64'(sram_addr), 64'd0);
`endif
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      cyc();
    end
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    for (int i = 0; i < int'(DEPTH) + 10; i++) begin
      if (!busy) break;
      cyc();
    end
    check("resweep_done", 64'(busy), 64'd0);
`endif
    rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
